// File: rtl/syndcnt_pkg.sv
// rtl/syndcnt_pkg.sv - shared types, defaults and prescale helper for the interval timer
package syndcnt_pkg;

  localparam int W_DEF  = 8;
  localparam int PW_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Prescaler compare value for a given select: 2**psel - 1
  function automatic int unsigned psel_limit(input int unsigned psel);
    return (32'd1 << psel) - 32'd1;
  endfunction

endpackage

// File: rtl/m_syndcnt_bit.sv
// rtl/m_syndcnt_bit.sv - one toggle/clear cell of the synchronous down-counter chain
module m_syndcnt_bit (
  input  logic CLK,
  input  logic load,
  input  logic ld_d,
  input  logic borrow_in,
  input  logic en,
  output logic Q,
  output logic borrow_out
);

  logic q_q;

  // A bit toggles on a decrement only when every lower bit is zero
  always_ff @(posedge CLK) begin
    if (load) begin
      q_q <= ld_d;
    end else if (en && borrow_in) begin
      q_q <= ~q_q;
    end
  end

  assign Q          = q_q;
  assign borrow_out = borrow_in & ~q_q;

endmodule

// File: rtl/syndcnt_timer_ctrl.sv
// rtl/syndcnt_timer_ctrl.sv - interval timer FSM, prescaler, reload and interrupt around the counter chain
module syndcnt_timer_ctrl
  import syndcnt_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          CLK,
  input  logic          RESETL,
  input  logic          LD,
  input  logic [W-1:0]  DIN,
  input  logic          GO,
  input  logic          STOP,
  input  logic          MODE,
  input  logic [PW-1:0] PSEL,
  input  logic          IACK,
  output logic [W-1:0]  Q,
  output logic          RUN,
  output logic          TC,
  output logic          INTL
);

  localparam int PRW = (1 << PW) - 1;

  state_e         state_q, state_d;
  logic [W-1:0]   reload_q, reload_d;
  logic [PRW-1:0] pre_q, pre_d;
  logic           tc_q, tc_d;
  logic           intl_q, intl_d;

  logic [W-1:0]   cnt;
  logic [W:0]     borrow;
  logic           cnt_load, cnt_en;
  logic [W-1:0]   cnt_ld_val;
  logic [PRW-1:0] limit;
  logic           tick, wrap, cnt_zero;

  assign limit = PRW'(psel_limit(32'(PSEL)));
  assign tick  = (pre_q == limit);
  assign wrap  = (pre_q >= limit);
  // The borrow out of the top cell is high exactly when the whole counter is zero
  assign cnt_zero = borrow[W];

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    reload_d   = LD ? DIN : reload_q;
    tc_d       = 1'b0;
    intl_d     = IACK ? 1'b1 : intl_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld_val = reload_q;
    if (!RESETL) begin
      cnt_load   = 1'b1;
      cnt_ld_val = '0;
    end else if (STOP) begin
      state_d = ST_IDLE;
    end else if (GO && (state_q != ST_ARM)) begin
      state_d = ST_ARM;
    end else begin
      case (state_q)
        ST_ARM: begin
          state_d  = ST_COUNT;
          pre_d    = '0;
          cnt_load = 1'b1;
        end
        ST_COUNT: begin
          pre_d = wrap ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (!cnt_zero) begin
              cnt_en = 1'b1;
            end else begin
              tc_d   = 1'b1;
              intl_d = 1'b0;
              if (MODE) cnt_load = 1'b1;
              else      state_d  = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
      intl_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
      intl_q   <= intl_d;
    end
  end

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_cell
    m_syndcnt_bit u_bit (
      .CLK        (CLK),
      .load       (cnt_load),
      .ld_d       (cnt_ld_val[i]),
      .borrow_in  (borrow[i]),
      .en         (cnt_en),
      .Q          (cnt[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign Q    = cnt;
  assign RUN  = (state_q == ST_COUNT);
  assign TC   = tc_q;
  assign INTL = intl_q;

endmodule

// File: tb/tb_syndcnt_timer_ctrl.sv
// tb/tb_syndcnt_timer_ctrl.sv - vector table and scoreboard bench for syndcnt_timer_ctrl
module tb_syndcnt_timer_ctrl;

  logic       CLK = 1'b0;
  logic       RESETL, LD, GO, STOP, MODE, IACK;
  logic [7:0] DIN;
  logic [1:0] PSEL;
  logic [7:0] Q;
  logic       RUN, TC, INTL;

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  typedef struct {
    logic       rst_n;
    logic       ld;
    logic [7:0] din;
    logic       go;
    logic       stop;
    logic       mode;
    logic [1:0] psel;
    logic       iack;
    logic [7:0] eq;
    logic       erun;
    logic       etc;
    logic       eintl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  syndcnt_timer_ctrl #(.W(8), .PW(2)) dut (
    .CLK(CLK), .RESETL(RESETL), .LD(LD), .DIN(DIN), .GO(GO), .STOP(STOP),
    .MODE(MODE), .PSEL(PSEL), .IACK(IACK), .Q(Q), .RUN(RUN), .TC(TC), .INTL(INTL)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst_n, input logic ld, input logic [7:0] din,
                              input logic go, input logic stop, input logic mode,
                              input logic [1:0] psel, input logic iack, input logic [7:0] eq,
                              input logic erun, input logic etc, input logic eintl);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.din = din; v.go = go; v.stop = stop; v.mode = mode;
    v.psel = psel; v.iack = iack; v.eq = eq; v.erun = erun; v.etc = etc; v.eintl = eintl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge CLK);
    RESETL = v.rst_n; LD = v.ld; DIN = v.din; GO = v.go; STOP = v.stop;
    MODE = v.mode; PSEL = v.psel; IACK = v.iack;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("Q", Q, e.eq);
    chk("RUN", {7'd0, RUN}, {7'd0, e.erun});
    chk("TC", {7'd0, TC}, {7'd0, e.etc});
    chk("INTL", {7'd0, INTL}, {7'd0, e.eintl});
    step_no++;
  endtask

  initial begin
    int  t, p;
    logic iack_j, intl_exp;
    logic [7:0] q_exp;
    logic tc_exp;

    RESETL = 1'b0; LD = 1'b0; DIN = '0; GO = 1'b0; STOP = 1'b0;
    MODE = 1'b0; PSEL = '0; IACK = 1'b0;

    //          rst ld din  go st md ps ik   Q  run tc intl
    tbl.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 8'd5, 0, 0, 0, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd5, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd4, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd3, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd2, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 1, 8'd0, 0, 0, 1));
    // stop+go together mid-count, then restart
    tbl.push_back(mk(1, 1, 8'd6, 0, 0, 1, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 1, 0, 1, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd6, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd5, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd4, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 1, 1, 1, 0, 0, 8'd4, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd4, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 1, 0, 1, 0, 0, 8'd4, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd6, 1, 0, 1));
    // reload 2, LD at reload edge loads old value, later reload picks up 9
    tbl.push_back(mk(1, 1, 8'd2, 1, 0, 1, 0, 0, 8'd6, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd2, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 8'd9, 0, 0, 1, 0, 0, 8'd2, 1, 1, 0));
    tbl.push_back(mk(1, 1, 8'd9, 0, 0, 1, 0, 0, 8'd1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd9, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd8, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd7, 1, 0, 0));
    // reset mid-count with GO held, then RELOAD=0 auto-reload
    tbl.push_back(mk(0, 0, 8'd0, 1, 0, 1, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0, 1, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 1, 0, 1, 0, 0, 8'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 1, 1, 0, 0, 8'd0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Auto-reload with prescale 4: period 16, IACK coinciding with a terminal event
    apply(mk(1, 0, 8'd0, 0, 0, 1, 2, 1, 8'd0, 0, 0, 1));
    apply(mk(1, 1, 8'd3, 0, 0, 1, 2, 0, 8'd0, 0, 0, 1));
    apply(mk(1, 0, 8'd0, 1, 0, 1, 2, 0, 8'd0, 0, 0, 1));
    intl_exp = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      iack_j = (j == 20) || (j == 33) || (j == 34);
      tc_exp = 1'b0;
      if (j == 1) begin
        q_exp = 8'd3;
      end else begin
        t = j - 2;
        p = t % 16;
        if (p == 15) begin
          q_exp = 8'd3;
          tc_exp = 1'b1;
        end else begin
          q_exp = 8'(3 - (p + 1) / 4);
        end
      end
      if (tc_exp) intl_exp = 1'b0;
      else if (iack_j) intl_exp = 1'b1;
      apply(mk(1, 0, 8'd0, 0, 0, 1, 2, iack_j, q_exp, 1'b1, tc_exp, intl_exp));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
